// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide unit with its own adder, stalling the pipeline until the result is ready.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            kill_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] op_q, op_d;
  logic [XLEN-1:0] a_q, a_d, acc_q, acc_d, lo_q, lo_d, res_q, res_d;
  logic neg_q, neg_d, rneg_q, rneg_d;
  logic sa, sb, div_zero, div_ovf;
  logic [XLEN-1:0] abs1, abs2, step_acc, step_lo, q, r, fin;
  logic [XLEN:0] msum, sr, trial;
  logic [2*XLEN-1:0] prod, prod_c;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    res_d    = res_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    sa       = rs1_i[XLEN-1] & (funct3_i == 3'b001 | funct3_i == 3'b010 | funct3_i == 3'b100 | funct3_i == 3'b110);
    sb       = rs2_i[XLEN-1] & (funct3_i == 3'b001 | funct3_i == 3'b100 | funct3_i == 3'b110);
    abs1     = sa ? -rs1_i : rs1_i;
    abs2     = sb ? -rs2_i : rs2_i;
    div_zero = rs2_i == '0;
    div_ovf  = ~funct3_i[0] & (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) & (&rs2_i);
    // multiply: add-then-shift keeps the carry as the new top bit of hi
    msum     = {1'b0, acc_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    // divide: remainder never exceeds the divisor, so the signed trial fits XLEN+1 bits
    sr       = {acc_q, lo_q[XLEN-1]};
    trial    = sr - {1'b0, a_q};
    step_acc = op_q[2] ? (trial[XLEN] ? sr[XLEN-1:0] : trial[XLEN-1:0]) : msum[XLEN:1];
    step_lo  = op_q[2] ? {lo_q[XLEN-2:0], ~trial[XLEN]} : {msum[0], lo_q[XLEN-1:1]};
    prod     = {step_acc, step_lo};
    prod_c   = neg_q ? -prod : prod;
    q        = neg_q ? -step_lo : step_lo;
    r        = rneg_q ? -step_acc : step_acc;
    fin      = op_q[2] ? (op_q[1] ? r : q) : (op_q[1:0] == 2'b00 ? prod_c[XLEN-1:0] : prod_c[2*XLEN-1:XLEN]);
    if (kill_i) state_d = IDLE;
    else if (state_q == IDLE && start_i) begin
      op_d   = funct3_i;
      a_d    = funct3_i[2] ? abs2 : abs1;
      lo_d   = funct3_i[2] ? abs1 : abs2;
      acc_d  = '0;
      cnt_d  = '0;
      neg_d  = sa ^ sb;
      rneg_d = sa;
      state_d = RUN;
      if (funct3_i[2] && (div_zero || div_ovf)) begin
        state_d = DONE;
        res_d   = div_zero ? (funct3_i[1] ? rs1_i : '1) : (funct3_i[1] ? '0 : rs1_i);
      end
    end else if (state_q == RUN) begin
      acc_d = step_acc;
      lo_d  = step_lo;
      cnt_d = cnt_q == LAST ? '0 : cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        state_d = DONE;
        res_d   = fin;
      end
    end else if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      res_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
    end
  end
  assign busy_o   = state_q == RUN || (state_q == IDLE && start_i && !kill_i);
  assign done_o   = state_q == DONE;
  assign result_o = res_q;
endmodule
